// File: rtl/gpu_pkg.sv
// Shared channel state encoding, perf counter width and pointer helper for data_mem_arbiter.
// The perf width is only consumed when DATA_MEM_ARB_PERF_EN is defined.
package gpu_pkg;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        READ_WAITING   = 3'd1,
        WRITE_WAITING  = 3'd2,
        READ_RELAYING  = 3'd3,
        WRITE_RELAYING = 3'd4
    } mem_chan_state_t;

    localparam int PERF_CNT_BITS = 16;

    function automatic int wrap_inc(input int value, input int modulus);
        return (value + 1 >= modulus) ? 0 : value + 1;
    endfunction

endpackage

// File: rtl/mem_channel_fsm.sv
// One memory channel: owns the granted consumer index and the registered memory-side request.
// Reports completion and release pulses so the top can drive consumer ready and the claim mask.
//
// state          | meaning
// IDLE           | free; accepts a grant from the top-level selection chain
// READ_WAITING   | mem_read_valid held until mem_read_ready
// WRITE_WAITING  | mem_write_valid held until mem_write_ready
// READ_RELAYING  | consumer read ready held until its read valid drops
// WRITE_RELAYING | consumer write ready held until its write valid drops
module mem_channel_fsm
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int IDX_BITS      = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     grant_valid,
    input  logic                     grant_read,
    input  logic [IDX_BITS-1:0]      grant_idx,
    input  logic [ADDR_BITS-1:0]     grant_address,
    input  logic [DATA_BITS-1:0]     grant_data,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    output logic                     idle,
    output logic [IDX_BITS-1:0]      owner,
    output logic                     read_done,
    output logic                     write_done,
    output logic                     release_claim,
    output logic                     mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address,
    input  logic                     mem_read_ready,
    output logic                     mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address,
    output logic [DATA_BITS-1:0]     mem_write_data,
    input  logic                     mem_write_ready
);

    mem_chan_state_t     state_q, state_d;
    logic [IDX_BITS-1:0] owner_q;

    assign idle  = (state_q == IDLE);
    assign owner = owner_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        read_done     = 1'b0;
        write_done    = 1'b0;
        release_claim = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = grant_read ? READ_WAITING : WRITE_WAITING;
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    read_done = 1'b1;
                    state_d   = READ_RELAYING;
                end
            end
            WRITE_WAITING: begin
                if (mem_write_ready) begin
                    write_done = 1'b1;
                    state_d    = WRITE_RELAYING;
                end
            end
            READ_RELAYING: begin
                if (!consumer_read_valid[owner_q]) begin
                    release_claim = 1'b1;
                    state_d       = IDLE;
                end
            end
            WRITE_RELAYING: begin
                if (!consumer_write_valid[owner_q]) begin
                    release_claim = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q           <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
        end else begin
            if (state_q == IDLE && grant_valid) begin
                owner_q <= grant_idx;
                if (grant_read) begin
                    mem_read_valid   <= 1'b1;
                    mem_read_address <= grant_address;
                end else begin
                    mem_write_valid   <= 1'b1;
                    mem_write_address <= grant_address;
                    mem_write_data    <= grant_data;
                end
            end
            if (read_done) begin
                mem_read_valid <= 1'b0;
            end
            if (write_done) begin
                mem_write_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter from LSU data ports onto NUM_CHANNELS memory channels.
// Defining DATA_MEM_ARB_PERF_EN adds saturating served-read/served-write counters.
module data_mem_arbiter
    import gpu_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data [NUM_CONSUMERS],
    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]  mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data [NUM_CHANNELS],
    output logic [NUM_CHANNELS-1:0]  mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS],
    output logic [DATA_BITS-1:0]     mem_write_data [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_write_ready
`ifdef DATA_MEM_ARB_PERF_EN
    ,
    output logic [PERF_CNT_BITS-1:0] perf_reads_served,
    output logic [PERF_CNT_BITS-1:0] perf_writes_served
`endif
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    logic [NUM_CONSUMERS-1:0] claim_q, claim_d;
    logic [IDX_BITS-1:0]      rr_ptr_q, rr_ptr_d;
    logic [NUM_CHANNELS-1:0]  chan_idle, grant_valid, grant_read;
    logic [NUM_CHANNELS-1:0]  read_done, write_done, release_claim;
    logic [IDX_BITS-1:0]      grant_idx [NUM_CHANNELS];
    logic [IDX_BITS-1:0]      chan_owner [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     grant_address [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     grant_data [NUM_CHANNELS];

    // Channels arbitrate in index order; each sees the claims and pointer left by the previous one.
    always_comb begin
        logic [IDX_BITS-1:0] cand_idx;
        claim_d  = claim_q;
        rr_ptr_d = rr_ptr_q;
        cand_idx = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            grant_valid[ch]   = 1'b0;
            grant_read[ch]    = 1'b0;
            grant_idx[ch]     = '0;
            grant_address[ch] = '0;
            grant_data[ch]    = '0;
            if (chan_idle[ch]) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    cand_idx = IDX_BITS'((int'(rr_ptr_d) + k) % NUM_CONSUMERS);
                    if (!grant_valid[ch] && !claim_d[cand_idx] &&
                        (consumer_read_valid[cand_idx] || consumer_write_valid[cand_idx])) begin
                        grant_valid[ch]   = 1'b1;
                        grant_idx[ch]     = cand_idx;
                        grant_read[ch]    = consumer_read_valid[cand_idx];
                        grant_address[ch] = consumer_read_valid[cand_idx] ?
                                            consumer_read_address[cand_idx] :
                                            consumer_write_address[cand_idx];
                        grant_data[ch]    = consumer_write_data[cand_idx];
                    end
                end
                if (grant_valid[ch]) begin
                    claim_d[grant_idx[ch]] = 1'b1;
                    rr_ptr_d = IDX_BITS'(wrap_inc(int'(grant_idx[ch]), NUM_CONSUMERS));
                end
            end
        end
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (release_claim[ch]) begin
                claim_d[chan_owner[ch]] = 1'b0;
            end
        end
    end

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        mem_channel_fsm #(
            .ADDR_BITS     (ADDR_BITS),
            .DATA_BITS     (DATA_BITS),
            .NUM_CONSUMERS (NUM_CONSUMERS),
            .IDX_BITS      (IDX_BITS)
        ) u_chan (
            .clk                  (clk),
            .reset                (reset),
            .grant_valid          (grant_valid[ch]),
            .grant_read           (grant_read[ch]),
            .grant_idx            (grant_idx[ch]),
            .grant_address        (grant_address[ch]),
            .grant_data           (grant_data[ch]),
            .consumer_read_valid  (consumer_read_valid),
            .consumer_write_valid (consumer_write_valid),
            .idle                 (chan_idle[ch]),
            .owner                (chan_owner[ch]),
            .read_done            (read_done[ch]),
            .write_done           (write_done[ch]),
            .release_claim        (release_claim[ch]),
            .mem_read_valid       (mem_read_valid[ch]),
            .mem_read_address     (mem_read_address[ch]),
            .mem_read_ready       (mem_read_ready[ch]),
            .mem_write_valid      (mem_write_valid[ch]),
            .mem_write_address    (mem_write_address[ch]),
            .mem_write_data       (mem_write_data[ch]),
            .mem_write_ready      (mem_write_ready[ch])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            claim_q              <= '0;
            rr_ptr_q             <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            for (int i = 0; i < NUM_CONSUMERS; i++) begin
                consumer_read_data[i] <= '0;
            end
        end else begin
            claim_q  <= claim_d;
            rr_ptr_q <= rr_ptr_d;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                if (read_done[ch]) begin
                    consumer_read_ready[chan_owner[ch]] <= 1'b1;
                    consumer_read_data[chan_owner[ch]]  <= mem_read_data[ch];
                end
                if (write_done[ch]) begin
                    consumer_write_ready[chan_owner[ch]] <= 1'b1;
                end
                if (release_claim[ch]) begin
                    consumer_read_ready[chan_owner[ch]]  <= 1'b0;
                    consumer_write_ready[chan_owner[ch]] <= 1'b0;
                end
            end
        end
    end

`ifdef DATA_MEM_ARB_PERF_EN
    // One extra bit catches overflow so the counters can saturate.
    logic [PERF_CNT_BITS:0] reads_sum, writes_sum;

    always_comb begin
        reads_sum  = {1'b0, perf_reads_served};
        writes_sum = {1'b0, perf_writes_served};
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            reads_sum  = reads_sum + (PERF_CNT_BITS + 1)'(read_done[ch]);
            writes_sum = writes_sum + (PERF_CNT_BITS + 1)'(write_done[ch]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_reads_served  <= '0;
            perf_writes_served <= '0;
        end else begin
            perf_reads_served  <= reads_sum[PERF_CNT_BITS] ? '1 : reads_sum[PERF_CNT_BITS-1:0];
            perf_writes_served <= writes_sum[PERF_CNT_BITS] ? '1 : writes_sum[PERF_CNT_BITS-1:0];
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: dut has one channel, dut2 has two channels.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_data_mem_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // single-channel instance
    logic [3:0] crv, crr, cwv, cwr;
    logic [7:0] cra [4];
    logic [7:0] crd [4];
    logic [7:0] cwa [4];
    logic [7:0] cwd [4];
    logic [0:0] mrv, mrr, mwv, mwr;
    logic [7:0] mra [1];
    logic [7:0] mrd [1];
    logic [7:0] mwa [1];
    logic [7:0] mwd [1];

    // two-channel instance
    logic [3:0] prv, prr, pwv, pwr;
    logic [7:0] pra [4];
    logic [7:0] prd [4];
    logic [7:0] pwa [4];
    logic [7:0] pwd [4];
    logic [1:0] pmrv, pmrr, pmwv, pmwr;
    logic [7:0] pmra [2];
    logic [7:0] pmrd [2];
    logic [7:0] pmwa [2];
    logic [7:0] pmwd [2];

`ifdef DATA_MEM_ARB_PERF_EN
    logic [15:0] perf_rd, perf_wr, p_perf_rd, p_perf_wr;
`endif

    data_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(crv), .consumer_read_address(cra),
        .consumer_read_ready(crr), .consumer_read_data(crd),
        .consumer_write_valid(cwv), .consumer_write_address(cwa),
        .consumer_write_data(cwd), .consumer_write_ready(cwr),
        .mem_read_valid(mrv), .mem_read_address(mra),
        .mem_read_ready(mrr), .mem_read_data(mrd),
        .mem_write_valid(mwv), .mem_write_address(mwa),
        .mem_write_data(mwd), .mem_write_ready(mwr)
`ifdef DATA_MEM_ARB_PERF_EN
        , .perf_reads_served(perf_rd), .perf_writes_served(perf_wr)
`endif
    );

    data_mem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) dut2 (
        .clk(clk), .reset(reset),
        .consumer_read_valid(prv), .consumer_read_address(pra),
        .consumer_read_ready(prr), .consumer_read_data(prd),
        .consumer_write_valid(pwv), .consumer_write_address(pwa),
        .consumer_write_data(pwd), .consumer_write_ready(pwr),
        .mem_read_valid(pmrv), .mem_read_address(pmra),
        .mem_read_ready(pmrr), .mem_read_data(pmrd),
        .mem_write_valid(pmwv), .mem_write_address(pmwa),
        .mem_write_data(pmwd), .mem_write_ready(pmwr)
`ifdef DATA_MEM_ARB_PERF_EN
        , .perf_reads_served(p_perf_rd), .perf_writes_served(p_perf_wr)
`endif
    );

    task automatic clear_inputs();
        crv = '0; cwv = '0; prv = '0; pwv = '0;
        mrr = '0; mwr = '0; pmrr = '0; pmwr = '0;
        for (int i = 0; i < 4; i++) begin
            cra[i] = '0; cwa[i] = '0; cwd[i] = '0;
            pra[i] = '0; pwa[i] = '0; pwd[i] = '0;
        end
        mrd[0] = '0; pmrd[0] = '0; pmrd[1] = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        vectors++; if (crr !== 4'h0) begin miscompares++; $display("FAIL reset_read_ready got %h want 0", crr); end
        vectors++; if (cwr !== 4'h0) begin miscompares++; $display("FAIL reset_write_ready got %h want 0", cwr); end
        vectors++; if (mrv !== 1'b0) begin miscompares++; $display("FAIL reset_mem_read_valid got %b want 0", mrv); end
        vectors++; if (mwv !== 1'b0) begin miscompares++; $display("FAIL reset_mem_write_valid got %b want 0", mwv); end
        vectors++; if (mra[0] !== 8'h00) begin miscompares++; $display("FAIL reset_mem_read_addr got %h want 00", mra[0]); end
        vectors++; if (crd[2] !== 8'h00) begin miscompares++; $display("FAIL reset_read_data got %h want 00", crd[2]); end
        vectors++; if (pmwv !== 2'b00) begin miscompares++; $display("FAIL reset_dut2_mem_write_valid got %b want 00", pmwv); end
        vectors++; if (prr !== 4'h0) begin miscompares++; $display("FAIL reset_dut2_read_ready got %h want 0", prr); end
        reset = 1'b1;
        @(negedge clk);
    endtask

    // Zero-wait memory: ready is driven during the cycle mem_read_valid is first seen.
    // Consumer ready then shows up in the third cycle counting the request cycle.
    task automatic test_read_basic();
        do_reset();
        cra[2] = 8'h10; crv[2] = 1'b1;
        @(negedge clk);
        vectors++; if (mrv[0] !== 1'b1 || mra[0] !== 8'h10) begin miscompares++; $display("FAIL basic_mem_req got valid=%b addr=%h want 1/10", mrv[0], mra[0]); end
        vectors++; if (crr !== 4'h0) begin miscompares++; $display("FAIL basic_early_ready got %h want 0", crr); end
        mrr[0] = 1'b1; mrd[0] = 8'hA5;
        @(negedge clk);
        mrr[0] = 1'b0; mrd[0] = 8'h00;
        vectors++; if (crr !== 4'b0100) begin miscompares++; $display("FAIL basic_ready got %h want 4", crr); end
        vectors++; if (crd[2] !== 8'hA5) begin miscompares++; $display("FAIL basic_data got %h want a5", crd[2]); end
        vectors++; if (mrv[0] !== 1'b0) begin miscompares++; $display("FAIL basic_mem_valid_drop got %b want 0", mrv[0]); end
        repeat (3) @(negedge clk);
        vectors++; if (crr !== 4'b0100 || crd[2] !== 8'hA5) begin miscompares++; $display("FAIL basic_hold got ready=%h data=%h want 4/a5", crr, crd[2]); end
        crv[2] = 1'b0;
        @(negedge clk);
        vectors++; if (crr !== 4'h0) begin miscompares++; $display("FAIL basic_release got %h want 0", crr); end
    endtask

    task automatic test_read_stall();
        do_reset();
        cra[1] = 8'h33; crv[1] = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            vectors++; if (mrv[0] !== 1'b1 || mra[0] !== 8'h33) begin miscompares++; $display("FAIL stall_req_c%0d got valid=%b addr=%h want 1/33", i, mrv[0], mra[0]); end
            vectors++; if (crr !== 4'h0) begin miscompares++; $display("FAIL stall_early_ready_c%0d got %h want 0", i, crr); end
            @(negedge clk);
        end
        mrr[0] = 1'b1; mrd[0] = 8'h5A;
        @(negedge clk);
        mrr[0] = 1'b0;
        vectors++; if (crr !== 4'b0010 || crd[1] !== 8'h5A) begin miscompares++; $display("FAIL stall_done got ready=%h data=%h want 2/5a", crr, crd[1]); end
        crv[1] = 1'b0;
        @(negedge clk);
        vectors++; if (crr !== 4'h0) begin miscompares++; $display("FAIL stall_release got %h want 0", crr); end
    endtask

    task automatic test_boundaries();
        do_reset();
        mrr[0] = 1'b1; mwr[0] = 1'b1;
        @(negedge clk);
        vectors++; if (crr !== 4'h0 || cwr !== 4'h0) begin miscompares++; $display("FAIL idle_ready_ignored got r=%h w=%h want 0/0", crr, cwr); end
        mrr[0] = 1'b0; mwr[0] = 1'b0;
        cra[1] = 8'h55; cwa[1] = 8'h66; crv[1] = 1'b1; cwv[1] = 1'b1;
        @(negedge clk);
        vectors++; if (mrv[0] !== 1'b1 || mwv[0] !== 1'b0) begin miscompares++; $display("FAIL read_wins got rv=%b wv=%b want 1/0", mrv[0], mwv[0]); end
        vectors++; if (mra[0] !== 8'h55) begin miscompares++; $display("FAIL read_wins_addr got %h want 55", mra[0]); end
        crv[1] = 1'b0; cwv[1] = 1'b0;
        @(negedge clk);
        vectors++; if (mrv[0] !== 1'b1) begin miscompares++; $display("FAIL abandon_still_waiting got %b want 1", mrv[0]); end
        mrr[0] = 1'b1; mrd[0] = 8'h7E;
        @(negedge clk);
        mrr[0] = 1'b0;
        vectors++; if (crr !== 4'b0010 || crd[1] !== 8'h7E) begin miscompares++; $display("FAIL abandon_done got ready=%h data=%h want 2/7e", crr, crd[1]); end
        @(negedge clk);
        vectors++; if (crr !== 4'h0) begin miscompares++; $display("FAIL abandon_one_cycle got %h want 0", crr); end
        @(negedge clk);
        vectors++; if (mrv[0] !== 1'b0 || mwv[0] !== 1'b0) begin miscompares++; $display("FAIL abandon_no_regrant got rv=%b wv=%b want 0/0", mrv[0], mwv[0]); end
    endtask

    task automatic test_round_robin();
        logic [7:0] grants [4];
        logic [7:0] exp_grants [4];
        int ng;
        do_reset();
        exp_grants[0] = 8'd0; exp_grants[1] = 8'd3; exp_grants[2] = 8'd0; exp_grants[3] = 8'd3;
        for (int k = 0; k < 4; k++) grants[k] = 8'hFF;
        ng = 0;
        cwa[0] = 8'd0; cwd[0] = 8'h40; cwa[3] = 8'd3; cwd[3] = 8'h43;
        cwv[0] = 1'b1; cwv[3] = 1'b1;
        for (int cyc = 0; cyc < 100 && ng < 4; cyc++) begin
            @(negedge clk);
            if (mwv[0] && !mwr[0]) begin
                grants[ng] = mwa[0];
                ng++;
                mwr[0] = 1'b1;
            end else begin
                mwr[0] = 1'b0;
            end
            cwv[0] = !cwr[0];
            cwv[3] = !cwr[3];
        end
        cwv = '0;
        @(negedge clk);
        mwr = '0;
        repeat (3) @(negedge clk);
        vectors++; if (ng != 4) begin miscompares++; $display("FAIL rr_grant_count got %0d want 4 (timeout)", ng); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (grants[k] !== exp_grants[k]) begin miscompares++; $display("FAIL rr_grant%0d got %h want %h", k, grants[k], exp_grants[k]); end
        end
    endtask

    task automatic test_parallel_writes();
        logic [7:0] wr_addr [4];
        logic [7:0] wr_data [4];
        int wr_ch [4];
        int wr_cyc [4];
        int rdy_cnt [4];
        logic [3:0] prev_rdy;
        int nw;
        do_reset();
        nw = 0; prev_rdy = '0;
        for (int i = 0; i < 4; i++) begin
            wr_addr[i] = 8'hFF; wr_data[i] = 8'hFF; wr_ch[i] = -1; wr_cyc[i] = -1; rdy_cnt[i] = 0;
            pwa[i] = 8'(i); pwd[i] = 8'h40 + 8'(i);
        end
        pwv = 4'hF;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (pmwv == 2'b11) begin
                vectors++; if (pmwa[0] === pmwa[1]) begin miscompares++; $display("FAIL par_double_claim got addr %h on both channels want distinct", pmwa[0]); end
            end
            for (int ch = 0; ch < 2; ch++) begin
                if (pmwv[ch] && !pmwr[ch]) begin
                    if (nw < 4) begin
                        wr_addr[nw] = pmwa[ch]; wr_data[nw] = pmwd[ch]; wr_ch[nw] = ch; wr_cyc[nw] = cyc;
                    end
                    nw++;
                    pmwr[ch] = 1'b1;
                end else begin
                    pmwr[ch] = 1'b0;
                end
            end
            for (int i = 0; i < 4; i++) begin
                if (pwr[i] && !prev_rdy[i]) rdy_cnt[i]++;
                if (pwr[i]) pwv[i] = 1'b0;
            end
            prev_rdy = pwr;
        end
        vectors++; if (nw != 4) begin miscompares++; $display("FAIL par_write_count got %0d want 4", nw); end
        for (int k = 0; k < 4; k++) begin
            vectors++; if (wr_addr[k] !== 8'(k) || wr_ch[k] != k % 2) begin miscompares++; $display("FAIL par_order%0d got addr=%h ch=%0d want %h/%0d", k, wr_addr[k], wr_ch[k], 8'(k), k % 2); end
            vectors++; if (wr_data[k] !== 8'h40 + 8'(k)) begin miscompares++; $display("FAIL par_data%0d got %h want %h", k, wr_data[k], 8'h40 + 8'(k)); end
            vectors++; if (rdy_cnt[k] != 1) begin miscompares++; $display("FAIL par_ready%0d got %0d pulses want 1", k, rdy_cnt[k]); end
        end
        vectors++; if (wr_cyc[0] != wr_cyc[1] || wr_cyc[2] != wr_cyc[3] || wr_cyc[2] <= wr_cyc[0]) begin
            miscompares++; $display("FAIL par_timing got cycles %0d %0d %0d %0d want pairs 0/1 then 2/3", wr_cyc[0], wr_cyc[1], wr_cyc[2], wr_cyc[3]);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        cra[0] = 8'h22; crv[0] = 1'b1;
        @(negedge clk);
        vectors++; if (mrv[0] !== 1'b1) begin miscompares++; $display("FAIL midrst_waiting got %b want 1", mrv[0]); end
        #2;
        reset = 1'b0; mrr[0] = 1'b1; mrd[0] = 8'h99;
        #1;
        vectors++; if (mrv[0] !== 1'b0 || mwv[0] !== 1'b0) begin miscompares++; $display("FAIL midrst_async_mem got rv=%b wv=%b want 0/0", mrv[0], mwv[0]); end
        vectors++; if (crr !== 4'h0 || cwr !== 4'h0) begin miscompares++; $display("FAIL midrst_async_ready got r=%h w=%h want 0/0", crr, cwr); end
        @(negedge clk);
        mrr[0] = 1'b0; mrd[0] = 8'h00; cra[0] = 8'h23;
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (crr !== 4'h0) begin miscompares++; $display("FAIL midrst_stale_ready got %h want 0", crr); end
        vectors++; if (mrv[0] !== 1'b1 || mra[0] !== 8'h23) begin miscompares++; $display("FAIL midrst_fresh_req got valid=%b addr=%h want 1/23", mrv[0], mra[0]); end
        mrr[0] = 1'b1; mrd[0] = 8'h3C;
        @(negedge clk);
        mrr[0] = 1'b0;
        vectors++; if (crr !== 4'b0001 || crd[0] !== 8'h3C) begin miscompares++; $display("FAIL midrst_fresh_done got ready=%h data=%h want 1/3c", crr, crd[0]); end
        crv[0] = 1'b0;
        @(negedge clk);
        vectors++; if (crr !== 4'h0) begin miscompares++; $display("FAIL midrst_release got %h want 0", crr); end
    endtask

`ifdef DATA_MEM_ARB_PERF_EN
    task automatic run_txn(input int idx, input bit is_read, output bit timed_out);
        timed_out = 1'b1;
        if (is_read) crv[idx] = 1'b1; else cwv[idx] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            mrr[0] = mrv[0]; mwr[0] = mwv[0]; mrd[0] = 8'h11;
            if (crr[idx] || cwr[idx]) begin
                timed_out = 1'b0;
                break;
            end
        end
        crv[idx] = 1'b0; cwv[idx] = 1'b0; mrr = '0; mwr = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_perf();
        bit to;
        do_reset();
        run_txn(0, 1'b1, to); vectors++; if (to) begin miscompares++; $display("FAIL perf_txn0 got timeout want done"); end
        run_txn(1, 1'b1, to); vectors++; if (to) begin miscompares++; $display("FAIL perf_txn1 got timeout want done"); end
        run_txn(2, 1'b1, to); vectors++; if (to) begin miscompares++; $display("FAIL perf_txn2 got timeout want done"); end
        run_txn(3, 1'b0, to); vectors++; if (to) begin miscompares++; $display("FAIL perf_txn3 got timeout want done"); end
        run_txn(0, 1'b0, to); vectors++; if (to) begin miscompares++; $display("FAIL perf_txn4 got timeout want done"); end
        vectors++; if (perf_rd !== 16'd3) begin miscompares++; $display("FAIL perf_reads got %0d want 3", perf_rd); end
        vectors++; if (perf_wr !== 16'd2) begin miscompares++; $display("FAIL perf_writes got %0d want 2", perf_wr); end
        force dut.perf_reads_served = 16'hFFFF;
        @(negedge clk);
        release dut.perf_reads_served;
        run_txn(1, 1'b1, to); vectors++; if (to) begin miscompares++; $display("FAIL perf_txn5 got timeout want done"); end
        vectors++; if (perf_rd !== 16'hFFFF) begin miscompares++; $display("FAIL perf_saturate got %h want ffff", perf_rd); end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_read_basic();
        test_read_stall();
        test_boundaries();
        test_round_robin();
        test_parallel_writes();
        test_reset_midflight();
`ifdef DATA_MEM_ARB_PERF_EN
        test_perf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
